aes_key_sched_ctrl: RTL

Sequential controller for AES-128 key expansion. It latches a 128-bit cipher key and iterates a single combinational round-key function once per cycle to produce round keys 0..10. The round keys are held in an internal 11-entry register file, which the AES round datapath reads by index. It sits between key load (host/config) and the cipher core, replacing a fully unrolled key schedule.

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_key_round.sv | 36 +++
 rtl/aes_key_sched_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, lookup functions and state encoding
//
// Contents:
//   AES_NR, AES_KEY_W : round count and key width for AES-128
//   aes_state_e       : controller state encoding (IDLE, EXPAND, DONE)
//   aes_rcon()        : round constant for round-key step 0..9, zero otherwise
//   sbox()            : forward AES S-box, 256 entries
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {
    AES_S_IDLE   = 2'd0,
    AES_S_EXPAND = 2'd1,
    AES_S_DONE   = 2'd2
  } aes_state_e;

  // S-box table, entry 0x00 in the most significant byte.
  localparam logic [2047:0] AES_SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return AES_SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// rtl/aes_key_round.sv - combinational AES-128 round-key step
//
// Ports:
//   prev_key [127:0] in  : round key n (w0 in the MSBs)
//   round    [3:0]   in  : step index n, selects rcon
//   next_key [127:0] out : round key n+1
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, g;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign g   = sub ^ {aes_rcon(round), 24'h000000};

  // Each new word chains off the one just produced.
  assign n0 = w0 ^ g;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key-expansion controller with 11-entry round-key file
//
// Optional build macro: AES_KEY_CACHE_EN (skip re-expansion when the same key is re-issued).
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, key_in     : expansion request and cipher key, taken when ready=1
//   ready, busy       : can accept start (IDLE/DONE) / expansion running (EXPAND)
//   done              : one-cycle pulse when the schedule completes
//   key_valid         : round-key file holds the full schedule of the last accepted key
//   rk_rd_idx/rk_rd_data : combinational round-key read, indices 11..15 read zero
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             key_valid,
  input  logic [3:0]       rk_rd_idx,
  output logic [KEY_W-1:0] rk_rd_data
);

  localparam logic [1:0] S_IDLE   = AES_S_IDLE;
  localparam logic [1:0] S_EXPAND = AES_S_EXPAND;
  localparam logic [1:0] S_DONE   = AES_S_DONE;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [KEY_W-1:0] rk [0:NR];
  logic [KEY_W-1:0] cur_key;
  logic [KEY_W-1:0] next_key;
  logic             accept;
  logic             cache_hit;

  assign ready  = (state == S_IDLE) || (state == S_DONE);
  assign busy   = (state == S_EXPAND);
  assign accept = start && ready;

`ifdef AES_KEY_CACHE_EN
  logic hit_pend;
  assign cache_hit = key_valid && (key_in == rk[0]);
`else
  assign cache_hit = 1'b0;
`endif

  // Source of the round step: rk[cnt].
  always_comb begin
    cur_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (cnt == 4'(i)) cur_key = rk[i];
    end
  end

  always_comb begin
    rk_rd_data = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_rd_idx == 4'(i)) rk_rd_data = rk[i];
    end
  end

  aes_key_round u_round (
    .prev_key (cur_key),
    .round    (cnt),
    .next_key (next_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
`ifdef AES_KEY_CACHE_EN
      hit_pend  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      hit_pend <= 1'b0;
      if (hit_pend) done <= 1'b1;
`endif

      if (state == S_EXPAND) begin
        for (int i = 1; i <= NR; i++) begin
          if (cnt == 4'(i - 1)) rk[i] <= next_key;
        end
        cnt <= cnt + 4'd1;
        if (cnt == 4'(NR - 1)) begin
          state     <= S_DONE;
          key_valid <= 1'b1;
          done      <= 1'b1;
        end
      end

      // accept is only possible outside EXPAND, so it never collides with the step above.
      if (accept) begin
        if (cache_hit) begin
          state <= S_DONE;
`ifdef AES_KEY_CACHE_EN
          hit_pend <= 1'b1;
`endif
        end else begin
          rk[0]     <= key_in;
          cnt       <= '0;
          key_valid <= 1'b0;
          state     <= S_EXPAND;
`ifdef AES_KEY_CACHE_EN
          // A pending hit belongs to the old key; do not let it flag the new one.
          done      <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
